// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared PC-control/comparator encodings, counter states and helpers
package branch_predict_unit_pkg;
    localparam int WIDTH_PCCTRL    = 4;
    localparam int PCCTRL_BRANCH   = 3;
    localparam int PCCTRL_BJ       = 2;
    localparam int PCCTRL_COND_LSB = 0;
    localparam int WIDTH_COMPOUT   = 2;

    typedef enum logic [1:0] {
        PCCTRL_B_EQ = 2'b00,
        PCCTRL_B_NE = 2'b01,
        PCCTRL_B_LT = 2'b10,
        PCCTRL_B_GE = 2'b11
    } bcond_e;

    localparam logic [WIDTH_COMPOUT-1:0] COMP_EQ = 2'b00;
    localparam logic [WIDTH_COMPOUT-1:0] COMP_LT = 2'b01;
    localparam logic [WIDTH_COMPOUT-1:0] COMP_GT = 2'b10;

    localparam logic [1:0] BPU_CTR_SNT = 2'b00;
    localparam logic [1:0] BPU_CTR_WNT = 2'b01;
    localparam logic [1:0] BPU_CTR_WT  = 2'b10;
    localparam logic [1:0] BPU_CTR_ST  = 2'b11;

    function automatic logic cond_taken(input bcond_e c, input logic [WIDTH_COMPOUT-1:0] comp);
        return (c == PCCTRL_B_EQ) ? (comp == COMP_EQ) :
               (c == PCCTRL_B_NE) ? (comp != COMP_EQ) :
               (c == PCCTRL_B_LT) ? (comp == COMP_LT) : (comp != COMP_LT);
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        return up ? ((c == BPU_CTR_ST) ? BPU_CTR_ST : c + 2'd1)
                  : ((c == BPU_CTR_SNT) ? BPU_CTR_SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// bpu_btb_array: direct-mapped BTB storage, async reset, IF lookup port, EX training read port, one write port
module bpu_btb_array
    import branch_predict_unit_pkg::*;
#(
    parameter int WIDTH_PC = 32,
    parameter int DEPTH    = 64,
    parameter int TAG_W    = 8,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    a_idx_i,
    output logic                a_valid_o,
    output logic [TAG_W-1:0]    a_tag_o,
    output logic [WIDTH_PC-1:0] a_target_o,
    output logic                a_uncond_o,
    output logic [1:0]          a_ctr_o,
    input  logic [IDX_W-1:0]    b_idx_i,
    output logic                b_valid_o,
    output logic [TAG_W-1:0]    b_tag_o,
    output logic                b_uncond_o,
    output logic [1:0]          b_ctr_o,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    w_idx_i,
    input  logic [TAG_W-1:0]    w_tag_i,
    input  logic [WIDTH_PC-1:0] w_target_i,
    input  logic                w_uncond_i,
    input  logic [1:0]          w_ctr_i
);
    logic                valid_q  [DEPTH];
    logic [TAG_W-1:0]    tag_q    [DEPTH];
    logic [WIDTH_PC-1:0] target_q [DEPTH];
    logic                uncond_q [DEPTH];
    logic [1:0]          ctr_q    [DEPTH];

    // Entry storage: reset clears every entry, otherwise one entry written per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                uncond_q[i] <= 1'b0;
                ctr_q[i]    <= BPU_CTR_WNT;
            end
        end else if (we_i) begin
            valid_q[w_idx_i]  <= 1'b1;
            tag_q[w_idx_i]    <= w_tag_i;
            target_q[w_idx_i] <= w_target_i;
            uncond_q[w_idx_i] <= w_uncond_i;
            ctr_q[w_idx_i]    <= w_ctr_i;
        end
    end

    assign a_valid_o  = valid_q[a_idx_i];
    assign a_tag_o    = tag_q[a_idx_i];
    assign a_target_o = target_q[a_idx_i];
    assign a_uncond_o = uncond_q[a_idx_i];
    assign a_ctr_o    = ctr_q[a_idx_i];
    assign b_valid_o  = valid_q[b_idx_i];
    assign b_tag_o    = tag_q[b_idx_i];
    assign b_uncond_o = uncond_q[b_idx_i];
    assign b_ctr_o    = ctr_q[b_idx_i];
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: IF-stage BTB prediction, EX-stage resolve/redirect and training; BPU_PERF_CNT_EN adds perf counters
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int WIDTH_PC  = 32,
    parameter int BTB_DEPTH = 64,
    parameter int TAG_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH_PC-1:0]      if_pc,
    output logic                     pred_taken,
    output logic [WIDTH_PC-1:0]      pred_target,
    input  logic                     ex_valid,
    input  logic [WIDTH_PCCTRL-1:0]  ex_PCCTRL,
    input  logic [WIDTH_COMPOUT-1:0] ex_COMPOut,
    input  logic [WIDTH_PC-1:0]      ex_pc,
    input  logic [WIDTH_PC-1:0]      ex_target,
    input  logic                     ex_predTaken,
    input  logic [WIDTH_PC-1:0]      ex_predTarget,
    output logic                     redirect,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0]              perf_branch,
    output logic [31:0]              perf_mispredict,
`endif
    output logic [WIDTH_PC-1:0]      redirectPC
);
    localparam int IDX_W = $clog2(BTB_DEPTH);

    logic [IDX_W-1:0]    if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                a_valid, a_uncond, b_valid, b_uncond;
    logic [TAG_W-1:0]    a_tag, b_tag;
    logic [WIDTH_PC-1:0] a_target;
    logic [1:0]          a_ctr, b_ctr;
    logic                gated, bj, act_taken, mispredict, ex_hit, we;
    logic [WIDTH_PC-1:0] act_target;
    logic                w_uncond;
    logic [1:0]          w_ctr;
    logic                unused_pc;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+2 +: TAG_W];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+2 +: TAG_W];
    assign unused_pc = ^{if_pc, ex_pc};

    bpu_btb_array #(.WIDTH_PC(WIDTH_PC), .DEPTH(BTB_DEPTH), .TAG_W(TAG_W)) u_btb (
        .clk(clk), .rst(rst),
        .a_idx_i(if_idx), .a_valid_o(a_valid), .a_tag_o(a_tag), .a_target_o(a_target),
        .a_uncond_o(a_uncond), .a_ctr_o(a_ctr),
        .b_idx_i(ex_idx), .b_valid_o(b_valid), .b_tag_o(b_tag), .b_uncond_o(b_uncond), .b_ctr_o(b_ctr),
        .we_i(we), .w_idx_i(ex_idx), .w_tag_i(ex_tag), .w_target_i(act_target),
        .w_uncond_i(w_uncond), .w_ctr_i(w_ctr)
    );

    // Lookup reads the stored table only; a write in this cycle shows up next cycle
    assign pred_taken  = a_valid && (a_tag == if_tag) && (a_uncond || a_ctr[1]);
    assign pred_target = a_target;

    assign gated      = ex_valid && ex_PCCTRL[PCCTRL_BRANCH];
    assign bj         = ex_PCCTRL[PCCTRL_BJ];
    assign act_taken  = !bj || cond_taken(bcond_e'(ex_PCCTRL[PCCTRL_COND_LSB +: 2]), ex_COMPOut);
    assign act_target = {ex_target[WIDTH_PC-1:1], 1'b0};
    assign mispredict = (act_taken != ex_predTaken) || (act_taken && ex_predTaken && (ex_predTarget != act_target));
    assign redirect   = gated && mispredict;
    assign redirectPC = (gated && act_taken) ? act_target : ex_pc + WIDTH_PC'(4);

    assign ex_hit   = b_valid && (b_tag == ex_tag);
    assign we       = gated && (ex_hit || act_taken);
    assign w_uncond = ex_hit ? b_uncond : !bj;
    assign w_ctr    = !ex_hit ? BPU_CTR_WT : (bj ? ctr_next(b_ctr, act_taken) : b_ctr);

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_branch_q, perf_branch_d, perf_mispredict_q, perf_mispredict_d;

    assign perf_branch_d     = perf_branch_q + {31'b0, gated};
    assign perf_mispredict_d = perf_mispredict_q + {31'b0, redirect};

    // Resolve and redirect event counters, free-running with wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branch_q     <= '0;
            perf_mispredict_q <= '0;
        end else begin
            perf_branch_q     <= perf_branch_d;
            perf_mispredict_q <= perf_mispredict_d;
        end
    end

    assign perf_branch     = perf_branch_q;
    assign perf_mispredict = perf_mispredict_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench for branch_predict_unit (directed scenarios plus model-based random)
module tb_branch_predict_unit;
    localparam logic [3:0] BEQ = 4'b1100, BNE = 4'b1101, BLT = 4'b1110, BGE = 4'b1111;
    localparam logic [3:0] JAL = 4'b1000, NOP = 4'b0000;

    typedef struct {
        logic        v;
        logic [3:0]  ctl;
        logic [1:0]  comp;
        logic [31:0] pc, tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        er;
        logic [31:0] epc, ipc;
        logic        ep;
        logic [31:0] etg;
    } cyc_t;

    typedef struct {
        logic        a;
        logic [31:0] v;
        string       n;
    } exp_t;

    logic        clk = 1'b0, rst;
    logic [31:0] if_pc, ex_pc, ex_target, ex_predTarget, pred_target, redirectPC;
    logic        pred_taken, ex_valid, ex_predTaken, redirect;
    logic [3:0]  ex_PCCTRL;
    logic [1:0]  ex_COMPOut;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_branch, perf_mispredict;
`endif

    exp_t sb[$], lk[$];
    int   n_pass = 0, n_total = 0;
    int unsigned m_br = 0, m_mp = 0;

    logic        m_v [64];
    logic [7:0]  m_tag [64];
    logic [31:0] m_tgt [64];
    logic        m_u [64];
    logic [1:0]  m_c [64];

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_PCCTRL(ex_PCCTRL), .ex_COMPOut(ex_COMPOut), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_predTaken(ex_predTaken), .ex_predTarget(ex_predTarget),
        .redirect(redirect),
`ifdef BPU_PERF_CNT_EN
        .perf_branch(perf_branch), .perf_mispredict(perf_mispredict),
`endif
        .redirectPC(redirectPC)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input cyc_t c, input string n);
        ex_valid      = c.v;
        ex_PCCTRL     = c.ctl;
        ex_COMPOut    = c.comp;
        ex_pc         = c.pc;
        ex_target     = c.tgt;
        ex_predTaken  = c.pt;
        ex_predTarget = c.ptgt;
        if_pc         = c.ipc;
        sb.push_back('{c.er, c.epc, n});
        lk.push_back('{c.ep, c.etg, n});
        if (!rst) begin
            m_br += {31'b0, c.v & c.ctl[3]};
            m_mp += {31'b0, c.er};
        end
    endtask

    task automatic test_reset();
        cyc_t c[2];
        exp_t e;
        c[0] = '{1'b0, NOP, 2'b00, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 32'h100, 1'b0, 32'h0};
        c[1] = '{1'b1, BEQ, 2'b00, 32'h100, 32'h140, 1'b0, 32'h0, 1'b1, 32'h140, 32'h100, 1'b0, 32'h0};
        foreach (c[k]) begin
            drive(c[k], $sformatf("reset[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
        end
        rst = 1'b0;
    endtask

    task automatic test_beq();
        cyc_t c[2];
        exp_t e;
        c[0] = '{1'b1, BEQ, 2'b00, 32'h100, 32'h140, 1'b0, 32'h0, 1'b1, 32'h140, 32'h100, 1'b0, 32'h0};
        c[1] = '{1'b0, NOP, 2'b00, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 32'h100, 1'b1, 32'h140};
        foreach (c[k]) begin
            drive(c[k], $sformatf("beq[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
        end
    endtask

    task automatic test_bne();
        cyc_t c[2];
        exp_t e;
        c[0] = '{1'b1, BNE, 2'b00, 32'h100, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104, 32'h100, 1'b1, 32'h140};
        c[1] = '{1'b0, NOP, 2'b00, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 32'h100, 1'b0, 32'h140};
        foreach (c[k]) begin
            drive(c[k], $sformatf("bne[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
        end
    endtask

    task automatic test_saturate();
        cyc_t c[7];
        exp_t e;
        c[0] = '{1'b1, BEQ, 2'b00, 32'h100, 32'h140, 1'b1, 32'h140, 1'b0, 32'h140, 32'h100, 1'b0, 32'h140};
        c[1] = '{1'b1, BEQ, 2'b00, 32'h100, 32'h140, 1'b1, 32'h140, 1'b0, 32'h140, 32'h100, 1'b1, 32'h140};
        c[2] = '{1'b1, BLT, 2'b01, 32'h100, 32'h140, 1'b1, 32'h140, 1'b0, 32'h140, 32'h100, 1'b1, 32'h140};
        c[3] = '{1'b1, BGE, 2'b10, 32'h100, 32'h140, 1'b1, 32'h140, 1'b0, 32'h140, 32'h100, 1'b1, 32'h140};
        c[4] = '{1'b1, BEQ, 2'b01, 32'h100, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104, 32'h100, 1'b1, 32'h140};
        c[5] = '{1'b1, BLT, 2'b10, 32'h100, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104, 32'h100, 1'b1, 32'h140};
        c[6] = '{1'b0, NOP, 2'b00, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 32'h100, 1'b0, 32'h140};
        foreach (c[k]) begin
            drive(c[k], $sformatf("saturate[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
        end
    endtask

    task automatic test_jalr();
        cyc_t c[6];
        exp_t e;
        c[0] = '{1'b1, JAL, 2'b00, 32'h200, 32'h280, 1'b0, 32'h0, 1'b1, 32'h280, 32'h100, 1'b0, 32'h140};
        c[1] = '{1'b0, NOP, 2'b00, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0, 32'h204, 32'h100, 1'b0, 32'h280};
        c[2] = '{1'b1, JAL, 2'b00, 32'h200, 32'h301, 1'b1, 32'h280, 1'b1, 32'h300, 32'h200, 1'b1, 32'h280};
        c[3] = '{1'b1, JAL, 2'b00, 32'h200, 32'h301, 1'b1, 32'h300, 1'b0, 32'h300, 32'h200, 1'b1, 32'h300};
        c[4] = '{1'b1, BNE, 2'b00, 32'h104, 32'h180, 1'b0, 32'h0, 1'b0, 32'h108, 32'h200, 1'b1, 32'h300};
        c[5] = '{1'b0, NOP, 2'b00, 32'h104, 32'h0, 1'b0, 32'h0, 1'b0, 32'h108, 32'h104, 1'b0, 32'h0};
        foreach (c[k]) begin
            drive(c[k], $sformatf("jalr[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
        end
    endtask

    task automatic test_invalid();
        cyc_t c[5];
        exp_t e;
        c[0] = '{1'b0, BEQ, 2'b01, 32'h200, 32'h140, 1'b1, 32'h300, 1'b0, 32'h204, 32'h200, 1'b1, 32'h300};
        c[1] = '{1'b1, NOP, 2'b00, 32'h200, 32'h140, 1'b1, 32'h300, 1'b0, 32'h204, 32'h200, 1'b1, 32'h300};
        c[2] = '{1'b1, NOP, 2'b00, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h200, 1'b1, 32'h300};
        c[3] = '{1'b1, BNE, 2'b00, 32'hFFFF_FFFC, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h200, 1'b1, 32'h300};
        c[4] = '{1'b0, JAL, 2'b00, 32'hFFFF_FFFC, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0};
        foreach (c[k]) begin
            drive(c[k], $sformatf("invalid[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
        end
`ifdef BPU_PERF_CNT_EN
        n_total++;
        if (perf_branch !== m_br || perf_mispredict !== m_mp) $display("FAIL perf_invalid: got %0d/%0d want %0d/%0d", perf_branch, perf_mispredict, m_br, m_mp); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        cyc_t c[3];
        exp_t e;
        c[0] = '{1'b1, JAL, 2'b00, 32'h300, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400, 32'h200, 1'b0, 32'h0};
        c[1] = '{1'b0, NOP, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 32'h304, 32'h300, 1'b0, 32'h0};
        c[2] = '{1'b0, NOP, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 32'h304, 32'h100, 1'b0, 32'h0};
        #2;
        rst = 1'b1;
        m_br = 0;
        m_mp = 0;
        foreach (c[k]) begin
            drive(c[k], $sformatf("reset_mid[%0d]", k));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
            rst = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [3:0] ctls [6];
        cyc_t       c;
        exp_t       e;
        logic       at, h;
        logic [5:0] j;
        ctls = '{BEQ, BNE, BLT, BGE, JAL, NOP};
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_u[i] = 1'b0; m_c[i] = 2'b01;
        end
        for (int n = 0; n < 400; n++) begin
            c.v    = ($urandom_range(0, 3) != 0);
            c.ctl  = ctls[$urandom_range(0, 5)];
            c.comp = 2'($urandom_range(0, 2));
            c.pc   = {16'h0, 8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00};
            c.tgt  = {20'h0, 12'($urandom)};
            c.pt   = 1'($urandom_range(0, 1));
            c.ptgt = $urandom_range(0, 1) ? {c.tgt[31:1], 1'b0} : {20'h0, 12'($urandom)};
            c.ipc  = {16'h0, 8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00};
            case (c.ctl[1:0])
                2'b00:   at = (c.comp == 2'b00);
                2'b01:   at = (c.comp != 2'b00);
                2'b10:   at = (c.comp == 2'b01);
                default: at = (c.comp != 2'b01);
            endcase
            if (!c.ctl[2]) at = 1'b1;
            c.er  = c.v && c.ctl[3] && ((at != c.pt) || (at && c.pt && c.ptgt != {c.tgt[31:1], 1'b0}));
            c.epc = (c.v && c.ctl[3] && at) ? {c.tgt[31:1], 1'b0} : c.pc + 32'd4;
            j     = c.ipc[7:2];
            c.ep  = m_v[j] && (m_tag[j] == c.ipc[15:8]) && (m_u[j] || m_c[j][1]);
            c.etg = m_tgt[j];
            drive(c, $sformatf("random[%0d]", n));
            #1;
            e = sb.pop_front(); n_total++;
            if (redirect !== e.a || redirectPC !== e.v) $display("FAIL %s redirect: got %b/%h want %b/%h", e.n, redirect, redirectPC, e.a, e.v); else n_pass++;
            e = lk.pop_front(); n_total++;
            if (pred_taken !== e.a || pred_target !== e.v) $display("FAIL %s pred: got %b/%h want %b/%h", e.n, pred_taken, pred_target, e.a, e.v); else n_pass++;
            step();
            j = c.pc[7:2];
            h = m_v[j] && (m_tag[j] == c.pc[15:8]);
            if (c.v && c.ctl[3]) begin
                if (h) begin
                    m_tgt[j] = {c.tgt[31:1], 1'b0};
                    if (c.ctl[2]) m_c[j] = at ? ((m_c[j] == 2'b11) ? 2'b11 : m_c[j] + 2'd1)
                                              : ((m_c[j] == 2'b00) ? 2'b00 : m_c[j] - 2'd1);
                end else if (at) begin
                    m_v[j] = 1'b1; m_tag[j] = c.pc[15:8]; m_tgt[j] = {c.tgt[31:1], 1'b0};
                    m_u[j] = !c.ctl[2]; m_c[j] = 2'b10;
                end
            end
        end
`ifdef BPU_PERF_CNT_EN
        n_total++;
        if (perf_branch !== m_br || perf_mispredict !== m_mp) $display("FAIL perf_random: got %0d/%0d want %0d/%0d", perf_branch, perf_mispredict, m_br, m_mp); else n_pass++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100; ex_valid = 1'b0; ex_PCCTRL = NOP; ex_COMPOut = 2'b00;
        ex_pc = 32'h100; ex_target = 32'h0; ex_predTaken = 1'b0; ex_predTarget = 32'h0;
        step();
        test_reset();
        test_beq();
        test_bne();
        test_saturate();
        test_jalr();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
